// File: rtl/rf_write_queue_if.sv
// Bundles the writeback request buses, the register-file write port and the
// forwarding lookups between the write queue and its surroundings.
interface rf_write_queue_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  s0_valid;
  logic                  s0_ready;
  logic [ADDR_WIDTH-1:0] s0_addr;
  logic [DATA_WIDTH-1:0] s0_data;

  logic                  s1_valid;
  logic                  s1_ready;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_data;

  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  logic [ADDR_WIDTH-1:0] fwd0_addr;
  logic                  fwd0_hit;
  logic [DATA_WIDTH-1:0] fwd0_data;
  logic [ADDR_WIDTH-1:0] fwd1_addr;
  logic                  fwd1_hit;
  logic [DATA_WIDTH-1:0] fwd1_data;

  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;

  // Producer side: writeback sources, forwarding requester, register file.
  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output fwd0_addr, fwd1_addr,
    input  s0_ready, s1_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  fwd0_hit, fwd0_data, fwd1_hit, fwd1_data,
    input  count, empty, full
  );

  // Queue side.
  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  fwd0_addr, fwd1_addr,
    output s0_ready, s1_ready,
    output rf_we, rf_waddr, rf_wdata,
    output fwd0_hit, fwd0_data, fwd1_hit, fwd1_data,
    output count, empty, full
  );
endinterface

// File: rtl/rf_write_queue.sv
// Register-file write queue: merges two writeback sources into the single
// write port of the register file, draining one entry per cycle in arrival
// order, and forwards pending (not yet written) data to the read ports.
module rf_write_queue #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               reset_n,
  rf_write_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [CW-1:0] free;
  logic          s0_ready;
  logic          s1_ready;
  logic          e0;
  logic          e1;
  logic          deq;
  logic [PW-1:0] s1_slot;

  // The head slot is always written out this cycle when occupied, so it is
  // credited as free space; s0 only needs one slot, s1 needs one more if s0
  // is also taking a slot in the same cycle.
  assign free     = CW'(DEPTH) - count + CW'(count != '0);
  assign s0_ready = (free >= CW'(1));
  assign e0       = bus.s0_valid & s0_ready & (bus.s0_addr != '0);
  assign s1_ready = (free >= (CW'(1) + CW'(e0)));
  assign e1       = bus.s1_valid & s1_ready & (bus.s1_addr != '0);
  assign deq      = (count != '0);
  assign s1_slot  = tail + PW'(e0);

  assign bus.s0_ready = s0_ready;
  assign bus.s1_ready = s1_ready;
  assign bus.rf_we    = deq;
  assign bus.rf_waddr = addr_mem[head];
  assign bus.rf_wdata = data_mem[head];
  assign bus.count    = count;
  assign bus.empty    = (count == '0);
  assign bus.full     = (count == CW'(DEPTH));

  // Pointer and occupancy update; writes to x0 never reach here because e0/e1
  // already exclude them, and reset drops everything that was pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(e0) + PW'(e1);
      count <= count + CW'(e0) + CW'(e1) - CW'(deq);
    end
  end

  // Entry storage; s0 is older so it takes the tail slot and s1 the one after.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (e0) begin
        addr_mem[tail] <= bus.s0_addr;
        data_mem[tail] <= bus.s0_data;
      end
      if (e1) begin
        addr_mem[s1_slot] <= bus.s1_addr;
        data_mem[s1_slot] <= bus.s1_data;
      end
    end
  end

  // Forwarding scans occupied entries oldest to youngest so the last match,
  // i.e. the youngest pending write to that register, wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot          = '0;
    bus.fwd0_hit  = 1'b0;
    bus.fwd0_data = '0;
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (CW'(i) < count) begin
        if ((bus.fwd0_addr != '0) && (addr_mem[slot] == bus.fwd0_addr)) begin
          bus.fwd0_hit  = 1'b1;
          bus.fwd0_data = data_mem[slot];
        end
        if ((bus.fwd1_addr != '0) && (addr_mem[slot] == bus.fwd1_addr)) begin
          bus.fwd1_hit  = 1'b1;
          bus.fwd1_data = data_mem[slot];
        end
      end
    end
  end
endmodule

// File: doc/rf_write_queue.md
RF_WRITE_QUEUE -- requirements
Module: rf_write_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries, power of 2, at least 2.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 s0_valid / s0_ready / s0_addr / s0_data  in / out / in ADDR_WIDTH / in DATA_WIDTH  writeback source 0 (ALU), older.
REQ-007 s1_valid / s1_ready / s1_addr / s1_data  in / out / in ADDR_WIDTH / in DATA_WIDTH  writeback source 1 (MUL/DIV), younger.
REQ-008 rf_we / rf_waddr / rf_wdata  out 1 / out ADDR_WIDTH / out DATA_WIDTH  drives the single write port of the 2-read/1-write register file.
REQ-009 fwdN_addr  input  ADDR_WIDTH  forwarding lookup address, N=0,1, paired with the file's read ports.
REQ-010 fwdN_hit / fwdN_data  out 1 / out DATA_WIDTH  pending-write match and its data, N=0,1.
REQ-011 count  output  clog2(DEPTH)+1  occupied entries; empty and full are 1-bit status outputs.

Function
REQ-012 SHALL be a circular FIFO with head/tail pointers that wrap modulo DEPTH; count SHALL never exceed DEPTH.
REQ-013 A handshake SHALL occur on a source when valid and ready are both high at a rising edge.
REQ-014 A handshake with addr==0 SHALL be consumed and discarded: no entry, no count change (x0 is hardwired).
REQ-015 free SHALL be DEPTH - count + (count!=0); this credits the same-cycle drain.
REQ-016 s0_ready SHALL be (free >= 1), independent of s0_valid and s0_addr.
REQ-017 s1_ready SHALL be (free >= 1 + e0), where e0 = s0_valid & s0_ready & (s0_addr!=0).
REQ-018 Both sources accepted in one cycle SHALL enqueue s0 at tail and s1 at tail+1; s1 is younger.
REQ-019 rf_we SHALL equal !empty combinationally, with rf_waddr/rf_wdata taken from the head entry.
REQ-020 The head SHALL be dequeued on every edge where rf_we is high, giving one register-file write per cycle.
REQ-021 Minimum latency SHALL be 1 cycle: an entry accepted at edge N drives rf_we during cycle N+1 if it is at the head.
REQ-022 Drain order SHALL equal enqueue order, including same-address writes (WAW order preserved).
REQ-023 fwdN_hit SHALL be 1 when any occupied entry, the head included, has addr == fwdN_addr and fwdN_addr != 0.
REQ-024 fwdN_data SHALL come from the youngest matching entry; it SHALL be 0 when fwdN_hit is 0.
REQ-025 Forwarding SHALL NOT consider same-cycle s0/s1 inputs; it is combinational from queue state only.
REQ-026 Simultaneous enqueue and dequeue when count==DEPTH SHALL be legal, with count = DEPTH - 1 + enqueued.
REQ-027 empty SHALL be (count==0) and full SHALL be (count==DEPTH).

Reset
REQ-028 While reset_n is low at an edge, head, tail and count SHALL clear to 0; entry storage need not clear.
REQ-029 After reset: rf_we=0, fwd0_hit=fwd1_hit=0, fwd data=0, empty=1, full=0, s0_ready=s1_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all pending entries, and no rf_we SHALL occur in the following cycle.
REQ-031 Handshakes at an edge where reset_n is low SHALL be ignored.

Verification
REQ-032 Single write: s0 writes addr 5, data 0xA5A5A5A5 at edge 1 -> cycle 2 has rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5; count returns to 0 after edge 2.
REQ-033 Dual enqueue: s0 writes (3, 0x11) and s1 writes (3, 0x22) in the same cycle, fwd0_addr=3 -> next cycle fwd0_hit=1, fwd0_data=0x22; the writes drain 0x11 then 0x22 on consecutive cycles.
REQ-034 Full/backpressure: with DEPTH=4, hold s0 and s1 valid with nonzero addresses every cycle -> count never exceeds 4, s1_ready=0 whenever free<2, and each write is drained exactly once in order.
REQ-035 x0 discard: s0 writes (0, 0xFFFFFFFF) -> s0_ready=1, count stays 0, rf_we stays 0; fwd0_addr=0 gives fwd0_hit=0.
REQ-036 Reset mid-flight: 3 entries queued, then reset_n=0 for one edge -> count=0, rf_we=0 and fwd hits 0 in the next cycle.
REQ-037 Wrap-around: 10 sequential single writes, addresses 1..10 with data equal to the address -> rf_waddr sequence is 1..10 with matching data and no loss across the pointer wrap.
